// File: rtl/second_largest_frame_ctrl.sv
// Frame controller tracking the largest and second-largest distinct samples.
// Ports: start/frame_len arm a frame; in_* stream samples; out_* present the result.
module second_largest_frame_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  frame_len,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [DATA_WIDTH-1:0] out_max2,
  output logic                  out_has2,
  output logic                  busy,
  output logic                  err_len
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic [DATA_WIDTH-1:0] max2_q;
  logic                  has2_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  err_len_q;

  logic [DATA_WIDTH-1:0] max_d;
  logic [DATA_WIDTH-1:0] max2_d;
  logic                  has2_d;
  logic                  last_beat;

  assign last_beat = (count_q == len_q - CNT_ONE);

  // New maximum demotes the old one; a value strictly below max becomes
  // second if it beats the current second or no second exists yet.
  always_comb begin
    max_d  = max_q;
    max2_d = max2_q;
    has2_d = has2_q;
    if (in_data > max_q) begin
      max_d  = in_data;
      max2_d = max_q;
      if (count_q != '0) has2_d = 1'b1;
    end else if ((in_data < max_q) &&
                 ((in_data > max2_q) || !has2_q)) begin
      max2_d = in_data;
      has2_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      max_q       <= '0;
      max2_q      <= '0;
      has2_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      err_len_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (frame_len != '0) begin
              len_q      <= frame_len;
              count_q    <= '0;
              max_q      <= '0;
              max2_q     <= '0;
              has2_q     <= 1'b0;
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              err_len_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (abort) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (in_valid) begin
            max_q   <= max_d;
            max2_q  <= max2_d;
            has2_q  <= has2_d;
            count_q <= count_q + CNT_ONE;
            if (last_beat) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_max2  = max2_q;
  assign out_has2  = has2_q;
  assign busy      = busy_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_second_largest_frame_ctrl.sv
// Scoreboard bench for second_largest_frame_ctrl.
// Expected results come from a distinct-value model of each frame.
module tb_second_largest_frame_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] frame_len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_max;
  logic [31:0] out_max2;
  logic        out_has2;
  logic        busy;
  logic        err_len;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        has2;
    logic [31:0] max2;
    logic [31:0] max;
  } res_t;

  res_t exp_q[$];

  second_largest_frame_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .frame_len(frame_len),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_max2(out_max2), .out_has2(out_has2),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: sort the distinct values, take the top two.
  function automatic res_t model(input logic [31:0] s[$]);
    logic [31:0] d[$];
    res_t r;
    bit found;
    foreach (s[i]) begin
      found = 0;
      foreach (d[j]) if (d[j] == s[i]) found = 1;
      if (!found) d.push_back(s[i]);
    end
    d.rsort();
    r.max  = d[0];
    r.has2 = (d.size() > 1);
    r.max2 = r.has2 ? d[1] : 32'd0;
    return r;
  endfunction

  // Monitor: pop on each new result, then demand it stays stable.
  res_t held;
  bit   seen = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %0h expected none",
                   {out_has2, out_max2, out_max});
        end else begin
          held = exp_q.pop_front();
          check("result", {31'd0, out_has2, out_max2},
                {31'd0, held.has2, held.max2});
          check("result_max", {32'd0, out_max}, {32'd0, held.max});
        end
        seen = 1;
      end else begin
        check("stable", {31'd0, out_has2, out_max2},
              {31'd0, held.has2, held.max2});
      end
    end else begin
      seen = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int len);
    start = 1'b1;
    frame_len = 16'(len);
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] v, input bit gaps);
    while (gaps && ($urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      step();
    end
    in_valid = 1'b1;
    in_data = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] s[$], input bit gaps,
                            input int hold);
    exp_q.push_back(model(s));
    arm(s.size());
    foreach (s[i]) beat(s[i], gaps);
    check("latency", {63'd0, out_valid}, 64'd1);
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("done_valid_low", {63'd0, out_valid}, 64'd0);
    check("done_busy_low", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {in_ready, out_valid, busy, err_len, out_has2},
          64'd0);
    check({name, "_data"}, {out_max, out_max2}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s[$];
    #3;
    check_reset_outs("reset");
    step();
    resetn = 1'b1;
    step();

    send_frame('{32'd5, 32'd9, 32'd3, 32'd7}, 0, 0);
    send_frame('{32'd6, 32'd6, 32'd6}, 0, 1);
    send_frame('{32'd8}, 0, 0);
    send_frame('{32'd1, 32'd4, 32'd4, 32'd2, 32'd4}, 1, 3);

    // Zero-length start.
    start = 1'b1;
    frame_len = '0;
    step();
    start = 1'b0;
    check("err_len", {61'd0, err_len, busy, in_ready}, 64'b100);
    step();
    check("err_len_clear", {63'd0, err_len}, 64'd0);
    send_frame('{32'hFFFF_FFFF, 32'd0}, 0, 0);

    // Abort on second beat of a three-beat frame.
    arm(3);
    beat(32'd50, 0);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 32'd60;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort", {61'd0, busy, in_ready, out_valid}, 64'd0);
    repeat (4) step();
    send_frame('{32'd3, 32'd1}, 0, 0);

    // Abort while the result waits.
    exp_q.push_back(model('{32'd2, 32'd7}));
    arm(2);
    beat(32'd2, 0);
    beat(32'd7, 0);
    step();
    abort = 1'b1;
    out_ready = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_done", {62'd0, busy, out_valid}, 64'd0);

    // Abort in IDLE together with start: start wins.
    abort = 1'b1;
    arm(1);
    abort = 1'b0;
    check("start_wins", {62'd0, busy, in_ready}, 64'b11);
    exp_q.push_back(model('{32'd11}));
    beat(32'd11, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-ACCUM.
    arm(4);
    beat(32'd20, 0);
    beat(32'd30, 0);
    resetn = 1'b0;
    #1;
    check_reset_outs("reset_accum");
    step();
    resetn = 1'b1;
    step();

    // Start held in DONE is ignored; then reset mid-DONE.
    exp_q.push_back(model('{32'd4, 32'd12}));
    arm(2);
    beat(32'd4, 0);
    beat(32'd12, 0);
    start = 1'b1;
    frame_len = 16'd3;
    repeat (3) step();
    check("start_in_done", {62'd0, out_valid, in_ready}, 64'b10);
    resetn = 1'b0;
    #1;
    check_reset_outs("reset_done");
    start = 1'b0;
    step();
    resetn = 1'b1;
    step();
    check("no_new_frame", {62'd0, busy, out_valid}, 64'd0);

    // Random frames with duplicates and full-range values.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 8);
      s.delete();
      for (int i = 0; i < n; i++) begin
        if (f % 3 == 0) s.push_back($urandom());
        else s.push_back(32'($urandom_range(0, 6)));
      end
      send_frame(s, 1, $urandom_range(0, 3));
    end

    repeat (3) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
